// File: rtl/ram_ctrl_pkg.sv
// ============================================================================
// Module      : ram_ctrl_pkg
// Description : Shared FSM state type and default widths for the RAM host
//               controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ram_ctrl_pkg;

   localparam int C_MEM_WIDTH = 8;
   localparam int C_ADDR_SIZE = 8;
   localparam int C_PERR_MAX  = 255;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      ADDR    = 3'd1,
      ACCESS  = 3'd2,
      DPIPE   = 3'd3,
      CAPTURE = 3'd4,
      RESP    = 3'd5
   } state_t;

   function automatic logic [7:0] sat_inc(input logic [7:0] value);
      return (value == 8'(C_PERR_MAX)) ? value : value + 8'd1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/ram_parity_chk.sv
// ============================================================================
// Module      : ram_parity_chk
// Description : Flags a mismatch between the XOR of a data word and the
//               parity bit delivered with it.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ram_parity_chk #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] data,
   input  logic             parity,
   input  logic             enable,
   output logic             mismatch
);

   assign mismatch = enable & ((^data) ^ parity);

endmodule

`default_nettype wire

// File: rtl/ram_host_ctrl.sv
// ============================================================================
// Module      : ram_host_ctrl
// Description : Single-outstanding host request/response controller for a
//               RAM with optional address and read-data pipeline stages.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ram_host_ctrl
   import ram_ctrl_pkg::*;
#(
   parameter int MEM_WIDTH = C_MEM_WIDTH,
   parameter int ADDR_SIZE = C_ADDR_SIZE,
   parameter int ADDR_PIPE = 1,
   parameter int DOUT_PIPE = 1,
   parameter int PARITY_EN = 1
) (
   input  logic                 clk,
   input  logic                 rst,

   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic                 req_write,
   input  logic [ADDR_SIZE-1:0] req_addr,
   input  logic [MEM_WIDTH-1:0] req_wdata,

   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic                 rsp_write,
   output logic [MEM_WIDTH-1:0] rsp_rdata,
   output logic                 rsp_perr,
   output logic                 rsp_verr,
   output logic [7:0]           perr_count,

   output logic [ADDR_SIZE-1:0] ram_addr,
   output logic [MEM_WIDTH-1:0] ram_din,
   output logic                 ram_enable,
   output logic                 ram_wr_en,
   output logic                 ram_rd_en,
   output logic                 ram_addr_en,
   output logic                 ram_dout_en,
   input  logic [MEM_WIDTH-1:0] ram_dout,
   input  logic                 ram_parity,
   input  logic                 ram_valid
);

   state_t                 r_state;
   logic                   r_write;
   logic [ADDR_SIZE-1:0]   r_addr;
   logic [MEM_WIDTH-1:0]   r_wdata;
   logic                   r_req_ready;
   logic                   r_enable;
   logic                   r_wr_en;
   logic                   r_rd_en;
   logic                   r_addr_en;
   logic                   r_dout_en;
   logic                   r_rsp_valid;
   logic                   r_rsp_write;
   logic [MEM_WIDTH-1:0]   r_rsp_rdata;
   logic                   r_rsp_perr;
   logic                   r_rsp_verr;
   logic [7:0]             r_perr_count;

   logic                   w_par_en;
   logic                   w_par_mismatch;

   assign w_par_en = (PARITY_EN != 0);

   ram_parity_chk #(
      .WIDTH    (MEM_WIDTH)
   ) u_parity_chk (
      .data     (ram_dout),
      .parity   (ram_parity),
      .enable   (w_par_en),
      .mismatch (w_par_mismatch)
   );

   // Strobes and response flags are set on the transition into the state
   // that owns them, so every output comes straight from a flop.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= IDLE;
         r_write      <= 1'b0;
         r_addr       <= '0;
         r_wdata      <= '0;
         r_req_ready  <= 1'b1;
         r_enable     <= 1'b0;
         r_wr_en      <= 1'b0;
         r_rd_en      <= 1'b0;
         r_addr_en    <= 1'b0;
         r_dout_en    <= 1'b0;
         r_rsp_valid  <= 1'b0;
         r_rsp_write  <= 1'b0;
         r_rsp_rdata  <= '0;
         r_rsp_perr   <= 1'b0;
         r_rsp_verr   <= 1'b0;
         r_perr_count <= 8'd0;
      end else begin
         r_enable  <= 1'b0;
         r_wr_en   <= 1'b0;
         r_rd_en   <= 1'b0;
         r_addr_en <= 1'b0;
         r_dout_en <= 1'b0;

         case (r_state)
            IDLE: begin
               if (req_valid && r_req_ready) begin
                  r_write     <= req_write;
                  r_addr      <= req_addr;
                  r_wdata     <= req_wdata;
                  r_req_ready <= 1'b0;
                  r_rsp_write <= req_write;
                  r_rsp_rdata <= '0;
                  r_rsp_perr  <= 1'b0;
                  r_rsp_verr  <= 1'b0;
                  if (ADDR_PIPE != 0) begin
                     r_state   <= ADDR;
                     r_addr_en <= 1'b1;
                  end else begin
                     r_state  <= ACCESS;
                     r_enable <= 1'b1;
                     r_wr_en  <= req_write;
                     r_rd_en  <= ~req_write;
                  end
               end
            end

            ADDR: begin
               r_state  <= ACCESS;
               r_enable <= 1'b1;
               r_wr_en  <= r_write;
               r_rd_en  <= ~r_write;
            end

            ACCESS: begin
               if (r_write) begin
                  r_state     <= RESP;
                  r_rsp_valid <= 1'b1;
               end else if (DOUT_PIPE != 0) begin
                  r_state   <= DPIPE;
                  r_dout_en <= 1'b1;
               end else begin
                  r_state <= CAPTURE;
               end
            end

            // The cycle right after ACCESS is where the RAM reports valid_out.
            DPIPE: begin
               r_state    <= CAPTURE;
               r_rsp_verr <= ~ram_valid;
            end

            CAPTURE: begin
               r_rsp_rdata <= ram_dout;
               r_rsp_perr  <= w_par_mismatch;
               if (DOUT_PIPE == 0) begin
                  r_rsp_verr <= ~ram_valid;
               end
               r_state     <= RESP;
               r_rsp_valid <= 1'b1;
            end

            RESP: begin
               if (rsp_ready) begin
                  r_state     <= IDLE;
                  r_rsp_valid <= 1'b0;
                  r_req_ready <= 1'b1;
                  if (r_rsp_perr) begin
                     r_perr_count <= sat_inc(r_perr_count);
                  end
               end
            end

            default: begin
               r_state     <= IDLE;
               r_req_ready <= 1'b1;
               r_rsp_valid <= 1'b0;
            end
         endcase
      end
   end

   assign req_ready   = r_req_ready;
   assign rsp_valid   = r_rsp_valid;
   assign rsp_write   = r_rsp_write;
   assign rsp_rdata   = r_rsp_rdata;
   assign rsp_perr    = r_rsp_perr;
   assign rsp_verr    = r_rsp_verr;
   assign perr_count  = r_perr_count;
   assign ram_addr    = r_addr;
   assign ram_din     = r_wdata;
   assign ram_enable  = r_enable;
   assign ram_wr_en   = r_wr_en;
   assign ram_rd_en   = r_rd_en;
   assign ram_addr_en = r_addr_en;
   assign ram_dout_en = r_dout_en;

endmodule

`default_nettype wire

// File: doc/ram_host_ctrl.md
RAM_HOST_CTRL -- requirements
Module: ram_host_ctrl

Interface
REQ-001 The block SHALL have parameter MEM_WIDTH, default 8, meaning the RAM data width in bits.
REQ-002 The block SHALL have parameter ADDR_SIZE, default 8, meaning the RAM address width in bits.
REQ-003 The block SHALL have parameter ADDR_PIPE, default 1, meaning the attached RAM registers its address (1) or uses it directly (0).
REQ-004 The block SHALL have parameter DOUT_PIPE, default 1, meaning the attached RAM registers its read data (1) or not (0).
REQ-005 The block SHALL have parameter PARITY_EN, default 1, meaning read-data parity is checked (1) or ignored (0).
REQ-006 The block SHALL have the following ports (name, direction, width, meaning):
- clk  in  1  clock.
- rst  in  1  reset: synchronous, active-high.
- req_valid  in  1  host request present.
- req_ready  out  1  controller accepts a request.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_SIZE  request address.
- req_wdata  in  MEM_WIDTH  write data.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  host accepts the response.
- rsp_write  out  1  response belongs to a write.
- rsp_rdata  out  MEM_WIDTH  read data; 0 for writes.
- rsp_perr  out  1  parity mismatch on this read.
- rsp_verr  out  1  RAM valid_out missing on this read.
- perr_count  out  8  saturating parity-error count.
- ram_addr  out  ADDR_SIZE  RAM address.
- ram_din  out  MEM_WIDTH  RAM write data.
- ram_enable, ram_wr_en, ram_rd_en, ram_addr_en, ram_dout_en  out  1 each  RAM strobes.
- ram_dout  in  MEM_WIDTH  RAM read data.
- ram_parity  in  1  RAM parity_out, equal to the XOR of ram_dout.
- ram_valid  in  1  RAM valid_out.

Function
REQ-007 The FSM SHALL have the states IDLE, ADDR, ACCESS, DPIPE, CAPTURE and RESP.
REQ-008 req_ready SHALL be 1 only in IDLE, and a request SHALL be accepted on an edge where req_valid and req_ready are both 1.
REQ-009 On acceptance, the block SHALL latch req_write, req_addr and req_wdata, and SHALL ignore the request inputs until it returns to IDLE.
REQ-010 From IDLE, the FSM SHALL go to ADDR if ADDR_PIPE=1, otherwise to ACCESS.
REQ-011 In ADDR, the block SHALL drive ram_addr_en=1 and ram_addr equal to the latched address for exactly one cycle, then go to ACCESS.
REQ-012 In ACCESS, the block SHALL drive ram_enable=1, ram_wr_en equal to the latched write flag, and ram_rd_en equal to the inverse of the latched write flag, for exactly one cycle.
REQ-013 After ACCESS, a write SHALL go to RESP.
REQ-014 After ACCESS, a read SHALL go to DPIPE if DOUT_PIPE=1, otherwise to CAPTURE.
REQ-015 In DPIPE, the block SHALL drive ram_dout_en=1 for exactly one cycle, then go to CAPTURE.
REQ-016 The block SHALL sample ram_valid in the cycle immediately after ACCESS for a read, and SHALL set rsp_verr if it is 0.
REQ-017 In CAPTURE, the block SHALL register ram_dout into rsp_rdata.
REQ-018 In CAPTURE, when PARITY_EN=1, rsp_perr SHALL be set if the XOR of ram_dout differs from ram_parity.
REQ-019 When PARITY_EN=0, rsp_perr SHALL be held at 0.
REQ-020 After CAPTURE, the FSM SHALL go to RESP.
REQ-021 In RESP, rsp_valid SHALL be 1, and all rsp_* outputs SHALL hold stable until the edge where rsp_ready is 1; the FSM SHALL then go to IDLE.
REQ-022 When rsp_ready is held at 1, the first rsp_valid cycle of a read SHALL occur 3+ADDR_PIPE+DOUT_PIPE cycles after the accept edge, and that of a write 2+ADDR_PIPE cycles after it.
REQ-023 ram_addr and ram_din SHALL hold the latched request values from ADDR through ACCESS.
REQ-024 All RAM strobes SHALL be 0 outside the states that assert them.
REQ-025 perr_count SHALL increment by 1 on each RESP exit with rsp_perr=1, and SHALL saturate at 255.
REQ-026 A new request SHALL be accepted only after the response handshake, so at most one transaction is outstanding.

Reset
REQ-027 When rst=1 at an edge, the FSM SHALL go to IDLE and all latched request values SHALL clear to 0, from any state.
REQ-028 After that reset edge, all RAM strobes, rsp_valid, rsp_write, rsp_perr, rsp_verr and perr_count SHALL be 0, and req_ready SHALL be 1 once rst=0.
REQ-029 A transaction interrupted by reset SHALL produce no response.

Structure
REQ-030 The shared package ram_ctrl_pkg SHALL hold the FSM state enum and the default width constants.
REQ-031 Parity comparison SHALL be placed in a sub-module ram_parity_chk (data, parity, enable -> mismatch).

Verification
REQ-032 With ADDR_PIPE=1 and DOUT_PIPE=1, write 0xA5 to address 0x10, then read 0x10 -> the write response arrives at +3 cycles; the read response arrives at +5 cycles with rsp_rdata=0xA5, rsp_perr=0, rsp_verr=0.
REQ-033 With ADDR_PIPE=0 and DOUT_PIPE=0, write 0x3C to address 0xFF, then read 0xFF -> rsp_rdata=0x3C, read latency 3 cycles, ram_addr_en and ram_dout_en never asserted.
REQ-034 Force ram_parity inverted during CAPTURE on a read of 0x01 -> rsp_perr=1 and perr_count increments 0->1; 256 such errors -> perr_count stays at 255.
REQ-035 Hold rsp_ready=0 for 10 cycles in RESP -> rsp_valid and data stay stable, req_ready=0 throughout, and req_valid pulses are ignored.
REQ-036 Assert rst in ACCESS during a read -> next cycle all strobes are 0 and the FSM is in IDLE, no rsp_valid follows, and perr_count=0.
